// File: rtl/pmem_arb_pkg.sv
// Shared types and helpers for the program-memory fetch arbiter.
package pmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_RESP    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Round-robin successor of idx among n consumers (wraps to 0).
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pmem_fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    // Scan offsets from the farthest to the nearest so the nearest set bit wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_i) + off) % N;
            if (req_i[idx]) begin
                grant_o = IDX_W'(idx);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_fetch_arbiter.sv
// Shares one program-memory read port between NUM_CONSUMERS fetch channels.
// Round-robin grant, one outstanding read. Optional last-hit tag enabled by
// defining PMEM_ARB_LASTHIT_EN: a repeat of the last fetched address is served
// from the tag (IDLE -> RESP) without touching memory.
module pmem_fetch_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int NUM_CONSUMERS         = 2,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [NUM_CONSUMERS-1:0]                             consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][PROGRAM_MEM_ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                             consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][PROGRAM_MEM_DATA_BITS-1:0]  consumer_read_data,
    output logic                                                 mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                                 mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]                     mem_read_data
);

    localparam int IDX_W = $clog2(NUM_CONSUMERS);

    arb_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                 grant_q, grant_d;
    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] data_q [NUM_CONSUMERS];
    logic [IDX_W-1:0]                 pick_idx;
    logic                             any_req;

    rr_pick #(
        .N     (NUM_CONSUMERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (consumer_read_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_idx),
        .any_o   (any_req)
    );

`ifdef PMEM_ARB_LASTHIT_EN
    logic                             tag_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] tag_addr_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0] tag_data_q;
    logic                             tag_hit;

    assign tag_hit = tag_valid_q && (tag_addr_q == consumer_read_address[pick_idx]);

    // Refill the tag on every completed memory read; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
            tag_data_q  <= '0;
        end else if (state_q == ARB_REQ && mem_read_ready) begin
            tag_valid_q <= 1'b1;
            tag_addr_q  <= addr_q;
            tag_data_q  <= mem_read_data;
        end
    end
`endif

    // Next-state logic for the fetch FSM and its control registers.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    addr_d  = consumer_read_address[pick_idx];
`ifdef PMEM_ARB_LASTHIT_EN
                    state_d = tag_hit ? ARB_RESP : ARB_REQ;
`else
                    state_d = ARB_REQ;
`endif
                end
            end
            ARB_REQ: begin
                if (mem_read_ready) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                // Hold here until the served core drops valid so it is not re-granted on a stale request.
                if (!consumer_read_valid[grant_q]) begin
                    rr_ptr_d = IDX_W'(rr_next_idx(int'(grant_q), NUM_CONSUMERS));
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM and control register update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
        end
    end

    assign mem_read_valid   = (state_q == ARB_REQ);
    assign mem_read_address = addr_q;

    for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_consumer
        // Per-core returned word; holds until the next grant to this core completes.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q[gi] <= '0;
            end else if (state_q == ARB_REQ && mem_read_ready && grant_q == IDX_W'(gi)) begin
                data_q[gi] <= mem_read_data;
`ifdef PMEM_ARB_LASTHIT_EN
            end else if (state_q == ARB_IDLE && any_req && tag_hit && pick_idx == IDX_W'(gi)) begin
                data_q[gi] <= tag_data_q;
`endif
            end
        end

        assign consumer_read_data[gi]  = data_q[gi];
        assign consumer_read_ready[gi] = (state_q == ARB_RESP) && (grant_q == IDX_W'(gi));
    end

endmodule
